// File: rtl/adc_delay_cal_sm.sv
// adc_delay_cal_sm: sweeps all 32 data-delay taps, checks the ADC test pattern at each, loads the eye centre.
// Latency: cal_start to cal_done is 32*(SETTLE_CYCLES+CHECK_SAMPLES+2)+2 clk cycles; manual tap load takes 1 cycle.
// Backpressure: none; cal_start/manual_tap_wr are ignored while cal_busy, packed_adc_dat is sampled every cycle.
// Ports: clk/reset (sync, active-high); cal_start, manual_tap/manual_tap_wr and tap_default from software;
//        packed_adc_dat plus pattern_a/pattern_b for the compare; adc_buf_data_delay + adc_buf_delay_data_reset
//        to the delay block; cal_busy/cal_done/cal_fail status, pass_map and eye_start/eye_width results.
module adc_delay_cal_sm #(
    parameter int SETTLE_CYCLES = 64,
    parameter int CHECK_SAMPLES = 256,
    parameter int MIN_EYE       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cal_start,
    input  logic [25:0] packed_adc_dat,
    input  logic [11:0] pattern_a,
    input  logic [11:0] pattern_b,
    input  logic [4:0]  tap_default,
    input  logic [4:0]  manual_tap,
    input  logic        manual_tap_wr,
    output logic [4:0]  adc_buf_data_delay,
    output logic        adc_buf_delay_data_reset,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_fail,
    output logic [31:0] pass_map,
    output logic [4:0]  eye_start,
    output logic [5:0]  eye_width
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_FINAL  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_SAMPLES) ? SETTLE_CYCLES : CHECK_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       state;
    logic [4:0]       tap;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      dat_q;       // {second sample, first sample}, over-range bits dropped
    logic             chk_vld_q;   // dat_q holds a word captured during CHECK
    logic             tap_fail_q;
    logic [4:0]       cur_start;
    logic [5:0]       cur_len;
    logic [4:0]       best_start;
    logic [5:0]       best_len;

    logic             ovr_unused;
    logic             word_bad;
    logic             pass_now;
    logic [4:0]       nxt_cur_start;
    logic [5:0]       nxt_cur_len;
    logic [4:0]       nxt_best_start;
    logic [5:0]       nxt_best_len;
    logic [5:0]       half_w;
    logic [4:0]       centre_tap;
    logic             eye_ok;

    assign ovr_unused = packed_adc_dat[13] ^ packed_adc_dat[0];
    assign cal_busy   = (state != ST_IDLE);
    assign word_bad   = (dat_q[11:0] != pattern_a) || (dat_q[23:12] != pattern_b);
    // In NEXT the last CHECK word is still in dat_q, so it is folded in here.
    assign pass_now   = !tap_fail_q && !(chk_vld_q && word_bad);

    // Run/best-window update for the tap finishing this cycle; also used to
    // produce the final result on the same edge as the last tap is recorded.
    always_comb begin
        nxt_cur_len    = pass_now ? (cur_len + 6'd1) : 6'd0;
        nxt_cur_start  = (pass_now && (cur_len == 6'd0)) ? tap : cur_start;
        nxt_best_start = best_start;
        nxt_best_len   = best_len;
        if (nxt_cur_len > best_len) begin
            nxt_best_start = nxt_cur_start;
            nxt_best_len   = nxt_cur_len;
        end
        half_w     = (nxt_best_len - 6'd1) >> 1;
        centre_tap = nxt_best_start + half_w[4:0];
        eye_ok     = (nxt_best_len >= 6'(MIN_EYE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= ST_IDLE;
            tap                      <= 5'd0;
            cnt                      <= '0;
            dat_q                    <= 24'd0;
            chk_vld_q                <= 1'b0;
            tap_fail_q               <= 1'b0;
            cur_start                <= 5'd0;
            cur_len                  <= 6'd0;
            best_start               <= 5'd0;
            best_len                 <= 6'd0;
            adc_buf_data_delay       <= 5'd0;
            adc_buf_delay_data_reset <= 1'b0;
            cal_done                 <= 1'b0;
            cal_fail                 <= 1'b0;
            pass_map                 <= 32'd0;
            eye_start                <= 5'd0;
            eye_width                <= 6'd0;
        end else begin
            adc_buf_delay_data_reset <= 1'b0;
            dat_q                    <= {packed_adc_dat[25:14], packed_adc_dat[12:1]};
            chk_vld_q                <= (state == ST_CHECK);
            case (state)
                ST_IDLE: begin
                    if (cal_start) begin
                        cal_done                 <= 1'b0;
                        cal_fail                 <= 1'b0;
                        pass_map                 <= 32'd0;
                        eye_start                <= 5'd0;
                        eye_width                <= 6'd0;
                        cur_start                <= 5'd0;
                        cur_len                  <= 6'd0;
                        best_start               <= 5'd0;
                        best_len                 <= 6'd0;
                        tap                      <= 5'd0;
                        // Strobe lands in the LOAD cycle with tap 0 on the bus.
                        adc_buf_data_delay       <= 5'd0;
                        adc_buf_delay_data_reset <= 1'b1;
                        state                    <= ST_LOAD;
                    end else if (manual_tap_wr) begin
                        adc_buf_data_delay       <= manual_tap;
                        adc_buf_delay_data_reset <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tap_fail_q <= 1'b0;
                    cnt        <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (chk_vld_q && word_bad) begin
                        tap_fail_q <= 1'b1;
                    end
                    if (cnt == CNT_W'(CHECK_SAMPLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_NEXT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    pass_map[tap] <= pass_now;
                    cur_start     <= nxt_cur_start;
                    cur_len       <= nxt_cur_len;
                    best_start    <= nxt_best_start;
                    best_len      <= nxt_best_len;
                    adc_buf_delay_data_reset <= 1'b1;
                    if (tap == 5'd31) begin
                        // Results and final strobe are registered here so they
                        // are presented during the FINAL cycle.
                        eye_start          <= nxt_best_start;
                        eye_width          <= nxt_best_len;
                        adc_buf_data_delay <= eye_ok ? centre_tap : tap_default;
                        cal_fail           <= !eye_ok;
                        state              <= ST_FINAL;
                    end else begin
                        tap                <= tap + 5'd1;
                        adc_buf_data_delay <= tap + 5'd1;
                        state              <= ST_LOAD;
                    end
                end
                ST_FINAL: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    cal_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_delay_cal_sm.sv
module tb_adc_delay_cal_sm;

    localparam int S  = 4;
    localparam int C  = 8;
    localparam int ME = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cal_start;
    logic [25:0] packed_adc_dat;
    logic [11:0] pattern_a;
    logic [11:0] pattern_b;
    logic [4:0]  tap_default;
    logic [4:0]  manual_tap;
    logic        manual_tap_wr;
    logic [4:0]  adc_buf_data_delay;
    logic        adc_buf_delay_data_reset;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [31:0] pass_map;
    logic [4:0]  eye_start;
    logic [5:0]  eye_width;

    adc_delay_cal_sm #(.SETTLE_CYCLES(S), .CHECK_SAMPLES(C), .MIN_EYE(ME)) dut (
        .clk(clk), .reset(reset), .cal_start(cal_start), .packed_adc_dat(packed_adc_dat),
        .pattern_a(pattern_a), .pattern_b(pattern_b), .tap_default(tap_default),
        .manual_tap(manual_tap), .manual_tap_wr(manual_tap_wr),
        .adc_buf_data_delay(adc_buf_data_delay), .adc_buf_delay_data_reset(adc_buf_delay_data_reset),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail), .pass_map(pass_map),
        .eye_start(eye_start), .eye_width(eye_width)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] good_map = 32'd0;   // taps whose data is clean
    int          since = 0;          // cycles since the last strobe (0 = LOAD cycle)
    int          strobe_cnt = 0;
    logic [4:0]  last_strobe_tap = 5'd0;
    int          g_tap[4] = '{-1, -1, -1, -1};   // single-word corruption: tap and since index
    int          g_since[4] = '{-1, -1, -1, -1};

    // Emulated delay block + ADC: the word is clean only if the currently
    // loaded tap is in good_map (and no one-off glitch is scheduled).
    always @(negedge clk) begin
        logic        bad;
        logic [11:0] sa, sb, flip;
        if (adc_buf_delay_data_reset) begin
            since = 0;
            strobe_cnt++;
            last_strobe_tap = adc_buf_data_delay;
        end else begin
            since++;
        end
        bad = !good_map[adc_buf_data_delay];
        for (int g = 0; g < 4; g++)
            if (g_tap[g] == int'(adc_buf_data_delay) && g_since[g] == since) bad = 1'b1;
        sa = pattern_a;
        sb = pattern_b;
        if (bad) begin
            flip = 12'($urandom_range(1, 4095));
            case ($urandom_range(0, 2))
                0:       sa = sa ^ flip;
                1:       sb = sb ^ flip;
                default: begin sa = sa ^ flip; sb = sb ^ flip; end
            endcase
        end
        packed_adc_dat = {sb, 1'($urandom), sa, 1'($urandom)};
    end

    // Reference: longest run of passing taps, lowest start on ties, centre tap.
    task automatic model(input logic [31:0] m, input logic [4:0] tdef,
                         output logic [4:0] es, output logic [5:0] ew,
                         output logic [4:0] ft, output logic f);
        int best, bstart, i, j;
        best = 0; bstart = 0; i = 0;
        while (i < 32) begin
            if (m[i]) begin
                j = i;
                while (j < 32 && m[j]) j++;
                if (j - i > best) begin best = j - i; bstart = i; end
                i = j;
            end else begin
                i++;
            end
        end
        es = 5'(bstart);
        ew = 6'(best);
        if (best >= ME) begin ft = 5'(bstart + (best - 1) / 2); f = 1'b0; end
        else begin ft = tdef; f = 1'b1; end
    endtask

    task automatic run_cal(input bit poke, output int lat, output bit tmo);
        @(negedge clk);
        cal_start = 1'b1;
        @(posedge clk);
        #1 cal_start = 1'b0;
        lat = 0;
        tmo = 1'b0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (poke && lat >= 100 && lat < 104) begin
                cal_start = 1'b1; manual_tap_wr = 1'b1; manual_tap = 5'd31;
            end else begin
                cal_start = 1'b0; manual_tap_wr = 1'b0;
            end
            if (cal_done) break;
            if (lat >= 2000) begin tmo = 1'b1; break; end
        end
        cal_start = 1'b0;
        manual_tap_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({adc_buf_data_delay, adc_buf_delay_data_reset, cal_busy, cal_done, cal_fail,
             pass_map, eye_start, eye_width} !== 52'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got delay=%0d strobe=%b busy=%b done=%b fail=%b map=%h es=%0d ew=%0d, want all 0",
                     adc_buf_data_delay, adc_buf_delay_data_reset, cal_busy, cal_done, cal_fail,
                     pass_map, eye_start, eye_width);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_manual();
        int lat; bit tmo;
        @(negedge clk);
        manual_tap = 5'd17; manual_tap_wr = 1'b1;
        @(posedge clk);
        #1 manual_tap_wr = 1'b0;
        n_cmp++;
        if (adc_buf_data_delay !== 5'd17 || adc_buf_delay_data_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL manual_load: got delay=%0d strobe=%b, want 17/1", adc_buf_data_delay, adc_buf_delay_data_reset);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (adc_buf_data_delay !== 5'd17 || adc_buf_delay_data_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL manual_hold: got delay=%0d strobe=%b, want 17/0", adc_buf_data_delay, adc_buf_delay_data_reset);
        end
        // cal_start wins over a simultaneous manual write
        @(negedge clk);
        manual_tap = 5'd5; manual_tap_wr = 1'b1; cal_start = 1'b1;
        @(posedge clk);
        #1 manual_tap_wr = 1'b0; cal_start = 1'b0;
        n_cmp++;
        if (adc_buf_data_delay !== 5'd0 || adc_buf_delay_data_reset !== 1'b1 || cal_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_priority: got delay=%0d strobe=%b busy=%b, want 0/1/1",
                     adc_buf_data_delay, adc_buf_delay_data_reset, cal_busy);
        end
        lat = 0; tmo = 1'b0;
        while (!cal_done) begin
            @(posedge clk); #1; lat++;
            if (lat > 2000) begin tmo = 1'b1; break; end
        end
        n_cmp++;
        if (tmo) begin n_bad++; $display("FAIL start_priority_done: cal_done not seen within 2000 cycles"); end
    endtask

    task automatic test_basic();
        int lat, base; bit tmo;
        pattern_a = 12'($urandom); pattern_b = 12'($urandom);
        tap_default = 5'd2;
        good_map = 32'h001F_FC00;
        base = strobe_cnt;
        run_cal(1'b0, lat, tmo);
        n_cmp++;
        if (tmo || lat != 450) begin n_bad++; $display("FAIL basic_latency: got %0d (timeout=%0b), want 450", lat, tmo); end
        n_cmp++;
        if (pass_map !== 32'h001F_FC00) begin n_bad++; $display("FAIL basic_pass_map: got %h want 001ffc00", pass_map); end
        n_cmp++;
        if (eye_start !== 5'd10 || eye_width !== 6'd11) begin
            n_bad++; $display("FAIL basic_eye: got start=%0d width=%0d want 10/11", eye_start, eye_width);
        end
        n_cmp++;
        if (adc_buf_data_delay !== 5'd15 || last_strobe_tap !== 5'd15 || cal_fail !== 1'b0 || cal_busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_final: got delay=%0d strobed=%0d fail=%b busy=%b want 15/15/0/0",
                              adc_buf_data_delay, last_strobe_tap, cal_fail, cal_busy);
        end
        n_cmp++;
        if (strobe_cnt - base != 33) begin n_bad++; $display("FAIL basic_strobes: got %0d want 33", strobe_cnt - base); end
    endtask

    task automatic test_windows();
        logic [31:0] maps[12];
        logic [4:0]  tdefs[12];
        logic [63:0] w;
        logic [4:0]  es, ft;
        logic [5:0]  ew;
        logic        f;
        int          lat, base, s, l;
        bit          tmo;
        maps[0] = 32'h0FF0_0078; maps[1] = 32'h0000_3C3C; maps[2] = 32'hFE00_0000;
        maps[3] = 32'hFFFF_FFFF; maps[4] = 32'h0000_0000; maps[5] = 32'h0000_0E00;
        for (int k = 0; k < 12; k++) tdefs[k] = 5'($urandom);
        tdefs[4] = 5'd9;
        for (int k = 6; k < 12; k++) begin
            s = $urandom_range(0, 31);
            l = $urandom_range(1, 32 - s);
            w = ((64'd1 << l) - 64'd1) << s;
            maps[k] = w[31:0] | ($urandom & $urandom & $urandom);
        end
        for (int k = 0; k < 12; k++) begin
            pattern_a = 12'($urandom); pattern_b = 12'($urandom);
            tap_default = tdefs[k];
            good_map = maps[k];
            base = strobe_cnt;
            model(maps[k], tdefs[k], es, ew, ft, f);
            run_cal(1'b0, lat, tmo);
            n_cmp++;
            if (tmo || pass_map !== maps[k]) begin
                n_bad++; $display("FAIL win%0d_pass_map: got %h want %h (timeout=%0b)", k, pass_map, maps[k], tmo);
            end
            n_cmp++;
            if (eye_start !== es || eye_width !== ew) begin
                n_bad++; $display("FAIL win%0d_eye: got start=%0d width=%0d want %0d/%0d", k, eye_start, eye_width, es, ew);
            end
            n_cmp++;
            if (adc_buf_data_delay !== ft || last_strobe_tap !== ft || cal_fail !== f || cal_done !== 1'b1) begin
                n_bad++; $display("FAIL win%0d_final: got delay=%0d strobed=%0d fail=%b done=%b want %0d/%0d/%b/1",
                                  k, adc_buf_data_delay, last_strobe_tap, cal_fail, cal_done, ft, ft, f);
            end
            n_cmp++;
            if (strobe_cnt - base != 33) begin n_bad++; $display("FAIL win%0d_strobes: got %0d want 33", k, strobe_cnt - base); end
        end
    endtask

    task automatic test_glitch();
        int lat; bit tmo;
        pattern_a = 12'($urandom); pattern_b = 12'($urandom);
        good_map = 32'h0001_FE00;                  // taps 9..16 clean
        g_tap[0] = 12; g_since[0] = S + C;         // last CHECK word: counts
        g_tap[1] = 10; g_since[1] = S + 1;         // first CHECK word: counts
        g_tap[2] = 14; g_since[2] = S;             // last SETTLE word: ignored
        g_tap[3] = 15; g_since[3] = S + C + 1;     // NEXT cycle word: ignored
        run_cal(1'b0, lat, tmo);
        g_tap = '{-1, -1, -1, -1};
        n_cmp++;
        if (tmo || pass_map !== 32'h0001_EA00) begin n_bad++; $display("FAIL glitch_pass_map: got %h want 0001ea00", pass_map); end
        n_cmp++;
        if (eye_start !== 5'd13 || eye_width !== 6'd4 || adc_buf_data_delay !== 5'd14 || cal_fail !== 1'b0) begin
            n_bad++; $display("FAIL glitch_eye: got start=%0d width=%0d delay=%0d fail=%b want 13/4/14/0",
                              eye_start, eye_width, adc_buf_data_delay, cal_fail);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, base; bit tmo;
        pattern_a = 12'($urandom); pattern_b = 12'($urandom);
        good_map = 32'h001F_FC00;
        base = strobe_cnt;
        run_cal(1'b1, lat, tmo);
        n_cmp++;
        if (tmo || lat != 450 || strobe_cnt - base != 33) begin
            n_bad++; $display("FAIL busy_ignore_timing: got latency=%0d strobes=%0d want 450/33", lat, strobe_cnt - base);
        end
        n_cmp++;
        if (pass_map !== 32'h001F_FC00 || adc_buf_data_delay !== 5'd15 || eye_width !== 6'd11) begin
            n_bad++; $display("FAIL busy_ignore_result: got map=%h delay=%0d width=%0d want 001ffc00/15/11",
                              pass_map, adc_buf_data_delay, eye_width);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        good_map = 32'hFFFF_FFFF;
        @(negedge clk);
        cal_start = 1'b1;
        @(posedge clk);
        #1 cal_start = 1'b0;
        repeat (2 * (S + C + 2) + S + 2) @(posedge clk);   // tap 2, inside CHECK
        #1;
        n_cmp++;
        if (pass_map !== 32'h0000_0003 || cal_busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_progress: got map=%h busy=%b want 00000003/1", pass_map, cal_busy);
        end
        @(negedge clk);
        reset = 1'b1;
        base = strobe_cnt;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({adc_buf_data_delay, adc_buf_delay_data_reset, cal_busy, cal_done, cal_fail,
             pass_map, eye_start, eye_width} !== 52'd0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got delay=%0d strobe=%b busy=%b done=%b map=%h, want all 0",
                     adc_buf_data_delay, adc_buf_delay_data_reset, cal_busy, cal_done, pass_map);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (strobe_cnt != base || cal_busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_idle: got strobes=%0d busy=%b want 0/0", strobe_cnt - base, cal_busy);
        end
    endtask

    initial begin
        reset = 1'b1; cal_start = 1'b0; manual_tap_wr = 1'b0; manual_tap = 5'd0;
        pattern_a = 12'h0; pattern_b = 12'h0; tap_default = 5'd0;
        test_reset();
        test_manual();
        test_basic();
        test_windows();
        test_glitch();
        test_busy_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
